axi_rd_arb3: RTL

AXI_RD_ARB3 -- requirements
Module: axi_rd_arb3

---
 rtl/axi_rd_arb3_if.sv | 77 +++++++
 rtl/axi_rd_arb3.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arb3_if.sv
// axi_rd_arb3_if -- AR/R bus bundle for the three-source read arbiter.
//
// Contents:
//   s0/s1/s2 AR channels (valid, ready, addr, id, len)
//   m AR channel, where the id is widened by two source bits
//   m R channel (valid, ready, id, data, last, resp)
//   s0/s1/s2 R channels
// Modports:
//   master : the arbiter's view. It drives m_ar*, sN_arready, sN_r* and m_rready.
//   slave  : the environment's view, with every direction reversed.
interface axi_rd_arb3_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int DATA_W = 64
);
  logic              s0_arvalid, s1_arvalid, s2_arvalid;
  logic              s0_arready, s1_arready, s2_arready;
  logic [ADDR_W-1:0] s0_araddr,  s1_araddr,  s2_araddr;
  logic [ID_W-1:0]   s0_arid,    s1_arid,    s2_arid;
  logic [7:0]        s0_arlen,   s1_arlen,   s2_arlen;

  logic              m_arvalid;
  logic              m_arready;
  logic [ADDR_W-1:0] m_araddr;
  logic [ID_W+1:0]   m_arid;
  logic [7:0]        m_arlen;

  logic              m_rvalid;
  logic              m_rready;
  logic [ID_W+1:0]   m_rid;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rlast;
  logic [1:0]        m_rresp;

  logic              s0_rvalid, s1_rvalid, s2_rvalid;
  logic              s0_rready, s1_rready, s2_rready;
  logic [ID_W-1:0]   s0_rid,    s1_rid,    s2_rid;
  logic [DATA_W-1:0] s0_rdata,  s1_rdata,  s2_rdata;
  logic              s0_rlast,  s1_rlast,  s2_rlast;
  logic [1:0]        s0_rresp,  s1_rresp,  s2_rresp;

  modport master (
    input  s0_arvalid, s1_arvalid, s2_arvalid,
    output s0_arready, s1_arready, s2_arready,
    input  s0_araddr, s1_araddr, s2_araddr,
    input  s0_arid, s1_arid, s2_arid,
    input  s0_arlen, s1_arlen, s2_arlen,
    output m_arvalid, m_araddr, m_arid, m_arlen,
    input  m_arready,
    input  m_rvalid, m_rid, m_rdata, m_rlast, m_rresp,
    output m_rready,
    output s0_rvalid, s1_rvalid, s2_rvalid,
    input  s0_rready, s1_rready, s2_rready,
    output s0_rid, s1_rid, s2_rid,
    output s0_rdata, s1_rdata, s2_rdata,
    output s0_rlast, s1_rlast, s2_rlast,
    output s0_rresp, s1_rresp, s2_rresp
  );

  modport slave (
    output s0_arvalid, s1_arvalid, s2_arvalid,
    input  s0_arready, s1_arready, s2_arready,
    output s0_araddr, s1_araddr, s2_araddr,
    output s0_arid, s1_arid, s2_arid,
    output s0_arlen, s1_arlen, s2_arlen,
    input  m_arvalid, m_araddr, m_arid, m_arlen,
    output m_arready,
    output m_rvalid, m_rid, m_rdata, m_rlast, m_rresp,
    input  m_rready,
    input  s0_rvalid, s1_rvalid, s2_rvalid,
    output s0_rready, s1_rready, s2_rready,
    input  s0_rid, s1_rid, s2_rid,
    input  s0_rdata, s1_rdata, s2_rdata,
    input  s0_rlast, s1_rlast, s2_rlast,
    input  s0_rresp, s1_rresp, s2_rresp
  );
endinterface

// File: rtl/axi_rd_arb3.sv
// axi_rd_arb3 -- three-source AXI read-address arbiter with R-channel demux.
//
// Ports:
//   aclk, areset_n        clock; asynchronous active-low reset
//   arb_en                when low, only source 0 can be granted
//   arb_mode[1:0]         0/3 fixed priority 0>1>2, 1 round robin, 2 weighted
//   weight_setting0/1/2   weighted-mode quota of consecutive grants (0 acts as 1)
//   bus                   axi_rd_arb3_if.master (all AR/R channels)
//   rid_err               sticky flag, set by any R beat whose source code is 3
//
// The downstream AR path is a single register slot. R beats are routed
// combinationally, using the top two bits of m_rid.
//
// Optional build macro AXI_RD_ARB3_OUTSTANDING_EN: this adds per-source
// outstanding-read counters. A source is masked from arbitration while its
// counter equals MAX_OUT.
module axi_rd_arb3 #(
  parameter int ADDR_W  = 32,
  parameter int ID_W    = 4,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 8
) (
  input  logic                 aclk,
  input  logic                 areset_n,
  input  logic                 arb_en,
  input  logic [1:0]           arb_mode,
  input  logic [15:0]          weight_setting0,
  input  logic [15:0]          weight_setting1,
  input  logic [15:0]          weight_setting2,
  axi_rd_arb3_if.master        bus,
  output logic                 rid_err
);

  function automatic logic [1:0] nxt_src(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  logic [2:0]  arv;
  logic [2:0]  arr;
  logic [2:0]  req;
  logic [2:0]  out_mask;
  logic        load;
  logic        take;
  logic        gnt_vld;
  logic [1:0]  gnt_src;
  logic [1:0]  start;
  logic [1:0]  rr_ptr;
  logic [1:0]  last_src;
  logic [15:0] grant_cnt;
  logic [15:0] w_cur;
  logic [15:0] quota;
  logic        prev_en;
  logic [1:0]  prev_mode;
  logic        cfg_change;

  logic [ADDR_W-1:0] sel_addr;
  logic [ID_W-1:0]   sel_id;
  logic [7:0]        sel_len;

  assign arv = {bus.s2_arvalid, bus.s1_arvalid, bus.s0_arvalid};
  assign req = (arb_en ? arv : {2'b00, arv[0]}) & ~out_mask;

  // The slot can accept a request when it is empty or is being drained this cycle.
  assign load = !bus.m_arvalid || bus.m_arready;
  assign take = areset_n && load && gnt_vld;

  assign arr = {take && (gnt_src == 2'd2), take && (gnt_src == 2'd1), take && (gnt_src == 2'd0)};
  assign bus.s0_arready = arr[0];
  assign bus.s1_arready = arr[1];
  assign bus.s2_arready = arr[2];

  assign cfg_change = (arb_en != prev_en) || (arb_mode != prev_mode);

  always_comb begin
    w_cur = weight_setting2;
    case (last_src)
      2'd0:    w_cur = weight_setting0;
      2'd1:    w_cur = weight_setting1;
      default: w_cur = weight_setting2;
    endcase
  end

  assign quota = (w_cur == 16'd0) ? 16'd1 : w_cur;

  // Every mode reduces to a search-start index. The search runs cyclically
  // from that index, so a lone requester is always found.
  always_comb begin
    int idx;
    start   = 2'd0;
    gnt_vld = 1'b0;
    gnt_src = 2'd0;
    idx     = 0;
    case (arb_mode)
      2'd1: start = rr_ptr;
      2'd2: begin
        if (req[last_src] && (grant_cnt < quota)) start = last_src;
        else                                      start = nxt_src(last_src);
      end
      default: start = 2'd0;
    endcase
    // Walk the candidates in reverse order, so the closest requester is written last and wins.
    for (int k = 2; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx > 2) idx = idx - 3;
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_src = 2'(idx);
      end
    end
  end

  always_comb begin
    sel_addr = bus.s0_araddr;
    sel_id   = bus.s0_arid;
    sel_len  = bus.s0_arlen;
    case (gnt_src)
      2'd1: begin
        sel_addr = bus.s1_araddr;
        sel_id   = bus.s1_arid;
        sel_len  = bus.s1_arlen;
      end
      2'd2: begin
        sel_addr = bus.s2_araddr;
        sel_id   = bus.s2_arid;
        sel_len  = bus.s2_arlen;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      bus.m_arvalid <= 1'b0;
      bus.m_araddr  <= '0;
      bus.m_arid    <= '0;
      bus.m_arlen   <= '0;
    end else if (load) begin
      bus.m_arvalid <= gnt_vld;
      if (gnt_vld) begin
        bus.m_araddr <= sel_addr;
        bus.m_arid   <= {gnt_src, sel_id};
        bus.m_arlen  <= sel_len;
      end
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rr_ptr    <= 2'd0;
      last_src  <= 2'd0;
      grant_cnt <= 16'd0;
      prev_en   <= 1'b0;
      prev_mode <= 2'd0;
    end else begin
      prev_en   <= arb_en;
      prev_mode <= arb_mode;
      if (take) begin
        last_src <= gnt_src;
        rr_ptr   <= nxt_src(gnt_src);
        if (cfg_change || (gnt_src != last_src)) grant_cnt <= 16'd1;
        else if (grant_cnt != 16'hffff)          grant_cnt <= grant_cnt + 16'd1;
      end else if (cfg_change) begin
        grant_cnt <= 16'd0;
      end
    end
  end

  // R path
  logic [1:0] r_sel;
  logic [2:0] rv;
  logic [2:0] rr;

  assign r_sel = bus.m_rid[ID_W+1:ID_W];
  assign rv    = {bus.m_rvalid && (r_sel == 2'd2), bus.m_rvalid && (r_sel == 2'd1),
                  bus.m_rvalid && (r_sel == 2'd0)};
  assign rr    = {bus.s2_rready, bus.s1_rready, bus.s0_rready};

  assign bus.s0_rvalid = rv[0];
  assign bus.s1_rvalid = rv[1];
  assign bus.s2_rvalid = rv[2];
  assign bus.s0_rid    = bus.m_rid[ID_W-1:0];
  assign bus.s1_rid    = bus.m_rid[ID_W-1:0];
  assign bus.s2_rid    = bus.m_rid[ID_W-1:0];
  assign bus.s0_rdata  = bus.m_rdata;
  assign bus.s1_rdata  = bus.m_rdata;
  assign bus.s2_rdata  = bus.m_rdata;
  assign bus.s0_rlast  = bus.m_rlast;
  assign bus.s1_rlast  = bus.m_rlast;
  assign bus.s2_rlast  = bus.m_rlast;
  assign bus.s0_rresp  = bus.m_rresp;
  assign bus.s1_rresp  = bus.m_rresp;
  assign bus.s2_rresp  = bus.m_rresp;

  // Beats with source code 3 have no owner. Accept them so the channel keeps moving.
  always_comb begin
    bus.m_rready = 1'b1;
    case (r_sel)
      2'd0:    bus.m_rready = rr[0];
      2'd1:    bus.m_rready = rr[1];
      2'd2:    bus.m_rready = rr[2];
      default: bus.m_rready = 1'b1;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n)                             rid_err <= 1'b0;
    else if (bus.m_rvalid && (r_sel == 2'd3))  rid_err <= 1'b1;
  end

`ifdef AXI_RD_ARB3_OUTSTANDING_EN
  localparam int OW = $clog2(MAX_OUT + 1);

  logic [OW-1:0] out_cnt [3];
  logic [2:0]    out_dec;

  assign out_dec = rv & rr & {3{bus.m_rlast}};

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      for (int n = 0; n < 3; n++) out_cnt[n] <= '0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (arr[n] && !out_dec[n])                         out_cnt[n] <= out_cnt[n] + 1'b1;
        else if (!arr[n] && out_dec[n] && out_cnt[n] != 0) out_cnt[n] <= out_cnt[n] - 1'b1;
      end
    end
  end

  always_comb begin
    out_mask = 3'b000;
    for (int n = 0; n < 3; n++) out_mask[n] = (out_cnt[n] == OW'(MAX_OUT));
  end
`else
  assign out_mask = 3'b000;
`endif

endmodule
